// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad column sequencer with synchronized row capture and per-sweep key map publish.
// Optional KEYPAD_GHOST_REJECT_EN: hold the previous map when a completed sweep shows >= 3 keys.
module keypad_scanner #(
  parameter int unsigned SETTLE_CYCLES = 1000,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  rows,
  output logic [3:0]  cols,
  output logic [15:0] keys_pressed,
  output logic        scan_done
);

  localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] settle_cnt;
  logic [1:0]    col;
  logic [15:0]   shadow;
  logic [15:0]   sweep_map;
  logic [15:0]   publish_map;
  logic [3:0]    sync_q [SYNC_STAGES];
  logic [3:0]    rows_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
    end else begin
      sync_q[0] <= rows;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign rows_sync = sync_q[SYNC_STAGES-1];

  // Shadow map with the current column's freshly sampled rows merged in.
  always_comb begin
    sweep_map = shadow;
    for (int unsigned r = 0; r < 4; r++) sweep_map[{r[1:0], col}] = ~rows_sync[r];
  end

`ifdef KEYPAD_GHOST_REJECT_EN
  logic [4:0] key_count;

  always_comb begin
    key_count = '0;
    for (int unsigned i = 0; i < 16; i++) key_count = key_count + 5'(sweep_map[i]);
    publish_map = (key_count >= 5'd3) ? keys_pressed : sweep_map;
  end
`else
  assign publish_map = sweep_map;
`endif

  always_comb begin
    cols = 4'b1111;
    if (state == SCAN) cols = ~(4'b0001 << col);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      settle_cnt   <= '0;
      col          <= '0;
      shadow       <= '0;
      keys_pressed <= '0;
      scan_done    <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      case (state)
        IDLE: begin
          settle_cnt <= '0;
          col        <= '0;
          shadow     <= '0;
          if (enable) state <= SCAN;
        end
        SCAN: begin
          if (!enable) begin
            // Abort discards the partial sweep, even on a sample edge.
            state      <= IDLE;
            settle_cnt <= '0;
            col        <= '0;
            shadow     <= '0;
          end else if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            col        <= col + 2'd1;
            if (col == 2'd3) begin
              keys_pressed <= publish_map;
              scan_done    <= 1'b1;
              shadow       <= '0;
            end else begin
              shadow <= sweep_map;
            end
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed/random bench for keypad_scanner with a behavioural keypad and sweep-level expectation model.
module tb_keypad_scanner;

  localparam int unsigned SETTLE = 4;
  localparam int unsigned SWEEP  = 4 * SETTLE;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [15:0] keys_pressed;
  logic        scan_done;

  logic [15:0] held;
  logic [15:0] exp_keys;
  int          vectors;
  int          miscompares;

  keypad_scanner #(.SETTLE_CYCLES(SETTLE), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .rows         (rows),
    .cols         (cols),
    .keys_pressed (keys_pressed),
    .scan_done    (scan_done)
  );

  always #5 clk = ~clk;

  // Keypad: a row reads low while any held key in it sits on a driven (low) column.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      rows[r] = 1'b1;
      for (int c = 0; c < 4; c++)
        if (held[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model_publish(input logic [15:0] prev, input logic [15:0] m);
`ifdef KEYPAD_GHOST_REJECT_EN
    if ($countones(m) >= 3) return prev;
`endif
    return m;
  endfunction

  function automatic logic [3:0] exp_cols(input int k);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << ((k % SWEEP) / SETTLE));
  endfunction

  // Called at cycle 0 of a sweep (just after entering SCAN or just after scan_done).
  task automatic sweep(input logic [15:0] h, input int n);
    held = h;
    for (int k = 1; k <= n; k++) begin
      tick();
      chk("cols", {12'h0, cols}, {12'h0, exp_cols(k)});
      if (k == SWEEP) exp_keys = model_publish(exp_keys, h);
      chk("scan_done", {15'h0, scan_done}, {15'h0, (k == SWEEP)});
      chk("keys", keys_pressed, exp_keys);
    end
  endtask

  task automatic enter();
    enable = 1'b1;
    tick();
    chk("enter_cols", {12'h0, cols}, 16'h000E);
    chk("enter_done", {15'h0, scan_done}, 16'h0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_cols"}, {12'h0, cols}, 16'h000F);
    chk({tag, "_done"}, {15'h0, scan_done}, 16'h0);
    chk({tag, "_keys"}, keys_pressed, exp_keys);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    held        = '0;
    exp_keys    = '0;
    reset       = 1'b1;
    enable      = 1'b0;
    tick();
    tick();
    check_idle("reset");
    reset = 1'b0;
    tick();
    check_idle("idle");

    // No keys, then a single held key, then two corners and release.
    enter();
    sweep(16'h0000, SWEEP);
    sweep(16'h0040, SWEEP);
    sweep(16'h0040, SWEEP);
    sweep(16'h8001, SWEEP);
    sweep(16'h0000, SWEEP);
    sweep(16'h0040, SWEEP);

    // Drop enable while column 2 is driven.
    sweep(16'h0040, 9);
    enable = 1'b0;
    tick();
    check_idle("abort_c2");
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("abort_idle");
    end
    enter();
    sweep(16'h0040, SWEEP);

    // Drop enable so that it is low on the column-3 sample edge.
    sweep(16'h0100, SWEEP - 1);
    enable = 1'b0;
    tick();
    check_idle("abort_sample");
    tick();
    check_idle("abort_sample_idle");
    enter();

    // Reset mid-sweep with keys held.
    sweep(16'h8001, 6);
    reset = 1'b1;
    tick();
    exp_keys = '0;
    check_idle("midreset");
    reset = 1'b0;
    tick();
    chk("reenter_cols", {12'h0, cols}, 16'h000E);
    sweep(16'h8001, SWEEP);

    // Three keys forming a ghost pattern, preceded by a single key.
    sweep(16'h0001, SWEEP);
    sweep(16'h0013, SWEEP);

    // Random key maps, one per sweep.
    for (int i = 0; i < 8; i++) begin
      logic [15:0] m;
      m = 16'($urandom) & 16'($urandom);
      sweep(m, SWEEP);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
